// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: reconfig core
// register map and sequencer state encoding.
package pll_reconfig_pkg;

  localparam logic [5:0] START = 6'd0;
  localparam logic [5:0] APPLY = 6'd2;
  localparam logic [5:0] N     = 6'd3;
  localparam logic [5:0] M     = 6'd4;
  localparam logic [5:0] C0    = 6'd5;
  localparam logic [5:0] K     = 6'd7;
  localparam logic [5:0] BW    = 6'd8;
  localparam logic [5:0] CP    = 6'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    PRST  = 3'd3,
    WLOCK = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pll_reconfig_seq_sync2.sv
// Two-flop level synchronizer for a slow asynchronous status input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Drives the eight-write PLL reconfiguration sequence over Avalon-MM, then
// pulses the PLL reset and waits for lock (done) or timeout (error).
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int          WR_GAP       = 7,
  parameter int          RESET_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter logic [31:0] N_VALUE      = 32'h10000,
  parameter logic [31:0] CP_VALUE     = 32'd1,
  parameter logic [31:0] BW_VALUE     = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_m,
  input  logic [31:0] cfg_k,
  input  logic [31:0] cfg_c0,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic        pll_reset,
  input  logic        locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam int RW = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(WR_GAP - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [31:0]   LOCK_LIMIT = 32'(LOCK_TIMEOUT);

  seq_state_t    state;
  logic [2:0]    step;
  logic [2:0]    load_step;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] rst_cnt;
  logic [31:0]   lock_cnt;
  logic [31:0]   lock_cnt_inc;
  logic [31:0]   m_q;
  logic [31:0]   k_q;
  logic [31:0]   c0_q;
  logic          pending;
  logic          locked_s;
  logic          accept;
  logic          seq_end;
  logic          restart;
  logic [5:0]    map_addr;
  logic [31:0]   map_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  assign accept       = (state == WRITE) && mgmt_write && !mgmt_waitrequest;
  assign lock_cnt_inc = sat_inc(lock_cnt);
  assign seq_end      = (state == WLOCK) && (locked_s || (lock_cnt_inc >= LOCK_LIMIT));
  // A start arriving on the final cycle is folded into the restart decision.
  assign restart      = pending || start;
  assign load_step    = ((state == IDLE) || (state == WLOCK)) ? 3'd0 : step + 3'd1;

  always_comb begin
    map_addr = START;
    map_data = 32'd0;
    case (load_step)
      3'd0: begin map_addr = START; map_data = 32'd0;    end
      3'd1: begin map_addr = M;     map_data = m_q;      end
      3'd2: begin map_addr = K;     map_data = k_q;      end
      3'd3: begin map_addr = N;     map_data = N_VALUE;  end
      3'd4: begin map_addr = C0;    map_data = c0_q;     end
      3'd5: begin map_addr = CP;    map_data = CP_VALUE; end
      3'd6: begin map_addr = BW;    map_data = BW_VALUE; end
      3'd7: begin map_addr = APPLY; map_data = 32'd0;    end
      default: ;
    endcase
  end

  // Parameter holding registers; newest start always wins.
  always_ff @(posedge clk) begin
    if (start) begin
      m_q  <= cfg_m;
      k_q  <= cfg_k;
      c0_q <= cfg_c0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      step           <= 3'd0;
      gap_cnt        <= '0;
      rst_cnt        <= '0;
      lock_cnt       <= 32'd0;
      pending        <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      mgmt_write     <= 1'b0;
      pll_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state != IDLE)) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            error          <= 1'b0;
            busy           <= 1'b1;
            step           <= load_step;
            mgmt_write     <= 1'b1;
            mgmt_address   <= map_addr;
            mgmt_writedata <= map_data;
            state          <= WRITE;
          end
        end
        WRITE: begin
          // Address/data are frozen here until the core accepts the write.
          if (accept) begin
            mgmt_write <= 1'b0;
            if (step == 3'd7) begin
              lock_cnt <= 32'd0;
              rst_cnt  <= '0;
              if (RESET_CYCLES > 0) begin
                pll_reset <= 1'b1;
                state     <= PRST;
              end else begin
                state <= WLOCK;
              end
            end else if (WR_GAP > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              step           <= load_step;
              mgmt_write     <= 1'b1;
              mgmt_address   <= map_addr;
              mgmt_writedata <= map_data;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            step           <= load_step;
            mgmt_write     <= 1'b1;
            mgmt_address   <= map_addr;
            mgmt_writedata <= map_data;
            state          <= WRITE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        PRST: begin
          if (rst_cnt == RST_LAST) begin
            pll_reset <= 1'b0;
            lock_cnt  <= 32'd0;
            state     <= WLOCK;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        WLOCK: begin
          if (seq_end) begin
            if (restart) begin
              pending        <= 1'b0;
              step           <= load_step;
              mgmt_write     <= 1'b1;
              mgmt_address   <= map_addr;
              mgmt_writedata <= map_data;
              state          <= WRITE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
              if (locked_s) done  <= 1'b1;
              else          error <= 1'b1;
            end
          end else begin
            lock_cnt <= lock_cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected Avalon writes, PLL reset
// pulses and done/error edges are queued with their cycle and popped by a monitor.
module tb_pll_reconfig_seq;

  localparam int EV_WR    = 0;
  localparam int EV_RST   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERRUP = 3;
  localparam int EV_ERRDN = 4;

  typedef struct {
    int     kind;
    int     cy;
    longint addr;
    longint data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cfg_m;
  logic [31:0] cfg_k;
  logic [31:0] cfg_c0;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_reset;
  logic        locked;
  logic        busy;
  logic        done;
  logic        error;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  lock_delay = -1;
  bit  mon_en = 1'b0;
  bit  drain_req = 1'b0;
  bit  rst_checked = 1'b0;
  bit  prev_err = 1'b0;
  int  rst_hi = 0;
  ev_t exp_q[$];

  pll_reconfig_seq #(
    .WR_GAP       (7),
    .RESET_CYCLES (8),
    .LOCK_TIMEOUT (100),
    .N_VALUE      (32'h10000),
    .CP_VALUE     (32'd1),
    .BW_VALUE     (32'd7)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_m            (cfg_m),
    .cfg_k            (cfg_k),
    .cfg_c0           (cfg_c0),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_write       (mgmt_write),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_reset        (pll_reset),
    .locked           (locked),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input int kind, input int cy, input longint addr, input longint data);
    ev_t e;
    e.kind = kind;
    e.cy   = cy;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int kind, input longint addr, input longint data);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d addr=0x%0h data=0x%0h", kind, cyc, addr, data);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_cycle", 64'(cyc), 64'(e.cy));
      chk("event_addr", 64'(addr), 64'(e.addr));
      chk("event_data", 64'(data), 64'(e.data));
    end
  endtask

  // Write n normally at c+1+8n; a stall of stall_n cycles on stall_step pushes it and all later ones.
  task automatic exp_writes(input int c, input longint m, input longint k, input longint c0,
                            input int stall_step, input int stall_n, input bit err_clr);
    longint a[8];
    longint d[8];
    a = '{0, 4, 7, 3, 5, 9, 8, 2};
    d = '{0, m, k, 'h10000, c0, 1, 7, 0};
    for (int n = 0; n < 8; n++) begin
      push(EV_WR, c + 1 + 8 * n + ((n >= stall_step) ? stall_n : 0), a[n], d[n]);
      if (n == 0 && err_clr) push(EV_ERRDN, c + 1, 0, 1);
    end
  endtask

  // pll_reset falls at c+66 after 8 cycles high; done 3 cycles after lock; timeout 100 cycles.
  task automatic exp_tail(input int c, input int stall_n, input int ldly, input bit has_done);
    int f;
    f = c + 66 + stall_n;
    push(EV_RST, f, 0, (64'd1 << 16) | 64'd8);
    if (ldly >= 0 && has_done) push(EV_DONE, f + ldly + 3, 0, 0);
    if (ldly < 0) push(EV_ERRUP, f + 100, 0, 0);
  endtask

  task automatic do_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0);
    cfg_m  = m;
    cfg_k  = k;
    cfg_c0 = c0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_test();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // PLL model: loses lock while in reset, relocks lock_delay cycles after release.
  initial begin
    int  lcnt;
    bit  armed;
    lcnt   = 0;
    armed  = 1'b0;
    locked = 1'b0;
    forever begin
      @(negedge clk);
      if (pll_reset === 1'b1) begin
        locked = 1'b0;
        armed  = 1'b1;
        lcnt   = 0;
      end else if (armed) begin
        if (lcnt == lock_delay) begin
          locked = 1'b1;
          armed  = 1'b0;
        end else begin
          lcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && cyc >= 2 && !rst_checked) begin
      rst_checked = 1'b1;
      chk("reset_busy", 64'(busy), 0);
      chk("reset_done", 64'(done), 0);
      chk("reset_error", 64'(error), 0);
      chk("reset_write", 64'(mgmt_write), 0);
      chk("reset_address", 64'(mgmt_address), 0);
      chk("reset_writedata", 64'(mgmt_writedata), 0);
      chk("reset_pll_reset", 64'(pll_reset), 0);
    end
    if (mon_en) begin
      if (mgmt_write && mgmt_waitrequest && exp_q.size() != 0) begin
        chk("stall_address", 64'(mgmt_address), 64'(exp_q[0].addr));
        chk("stall_writedata", 64'(mgmt_writedata), 64'(exp_q[0].data));
      end
      if (mgmt_write && !mgmt_waitrequest) got(EV_WR, longint'(mgmt_address), longint'(mgmt_writedata));
      if (pll_reset) begin
        rst_hi++;
      end else if (rst_hi != 0) begin
        got(EV_RST, 0, (longint'(busy) << 16) | longint'(rst_hi));
        rst_hi = 0;
      end
      if (done) got(EV_DONE, 0, longint'(busy));
      if (error && !prev_err) got(EV_ERRUP, 0, longint'(busy));
      if (!error && prev_err) got(EV_ERRDN, 0, longint'(busy));
      prev_err = error;
      if (drain_req) begin
        chk("queue_drained", 64'(exp_q.size()), 0);
        exp_q.delete();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset            = 1'b1;
    start            = 1'b0;
    cfg_m            = 32'd0;
    cfg_k            = 32'd0;
    cfg_c0           = 32'd0;
    mgmt_waitrequest = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Nominal sequence, lock 20 cycles after reset release.
    lock_delay = 20;
    c = cyc;
    exp_writes(c, 'h808, 'h1, 'h20302, 8, 0, 1'b0);
    exp_tail(c, 0, 20, 1'b1);
    do_start(32'h808, 32'h1, 32'h20302);
    finish_test();

    // Five cycles of back-pressure on the K write.
    c = cyc;
    exp_writes(c, 'h808, 'h1, 'h20302, 2, 5, 1'b0);
    exp_tail(c, 5, 20, 1'b1);
    do_start(32'h808, 32'h1, 32'h20302);
    wait_cycle(c + 17);
    mgmt_waitrequest = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mgmt_waitrequest = 1'b0;
    finish_test();

    // No lock: timeout after 100 cycles in WLOCK.
    lock_delay = -1;
    c = cyc;
    exp_writes(c, 'h11, 'h22, 'h33, 8, 0, 1'b0);
    exp_tail(c, 0, -1, 1'b0);
    do_start(32'h11, 32'h22, 32'h33);
    finish_test();

    // Start after error, then a second start during GAP: silent restart with new M.
    lock_delay = 20;
    c = cyc;
    exp_writes(c, 'h808, 'h1, 'h20302, 8, 0, 1'b1);
    exp_tail(c, 0, 20, 1'b0);
    exp_writes(c + 88, 'h160, 'h1, 'h20302, 8, 0, 1'b0);
    exp_tail(c + 88, 0, 20, 1'b1);
    do_start(32'h808, 32'h1, 32'h20302);
    wait_cycle(c + 12);
    do_start(32'h160, 32'h1, 32'h20302);
    finish_test();

    // Reset during PRST aborts the pulse after 3 cycles, busy drops.
    lock_delay = -1;
    c = cyc;
    exp_writes(c, 'h5, 'h6, 'h7, 8, 0, 1'b0);
    push(EV_RST, c + 61, 0, 3);
    do_start(32'h5, 32'h6, 32'h7);
    wait_cycle(c + 60);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    finish_test();

    // Full sequence after the mid-sequence reset.
    lock_delay = 20;
    c = cyc;
    exp_writes(c, 'h123, 'h2, 'h5, 8, 0, 1'b0);
    exp_tail(c, 0, 20, 1'b1);
    do_start(32'h123, 32'h2, 32'h5);
    finish_test();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
